// File: rtl/fpu_issue_ctrl_if.sv
// Bundle of pipeline request, FPU go/valid and writeback signals for fpu_issue_ctrl.
// master = issue controller side, slave = pipeline/FPU/writeback environment side.
interface fpu_issue_ctrl_if #(
  parameter int OPC_W = 4,
  parameter int RD_W  = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [OPC_W-1:0] req_op;
  logic             req_mode;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [RD_W-1:0]  req_rd;
  logic             req_wb_int;
  logic             flush;

  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [OPC_W-1:0] fpu_control;
  logic             fpu_mode;
  logic             fpu_go;
  logic [31:0]      fpu_c;
  logic             fpu_valid;

  logic             wb_valid;
  logic             wb_ready;
  logic [31:0]      wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic             wb_int;

  logic             busy;
  logic             timeout_err;

  modport master (
    input  req_valid, req_op, req_mode, req_rs1, req_rs2, req_rd, req_wb_int, flush,
    output req_ready,
    output fpu_a, fpu_b, fpu_control, fpu_mode, fpu_go,
    input  fpu_c, fpu_valid,
    output wb_valid, wb_data, wb_rd, wb_int,
    input  wb_ready,
    output busy, timeout_err
  );

  modport slave (
    output req_valid, req_op, req_mode, req_rs1, req_rs2, req_rd, req_wb_int, flush,
    input  req_ready,
    input  fpu_a, fpu_b, fpu_control, fpu_mode, fpu_go,
    output fpu_c, fpu_valid,
    input  wb_valid, wb_data, wb_rd, wb_int,
    output wb_ready,
    input  busy, timeout_err
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Core-side initiator for the FPU go/valid handshake, one op outstanding at a time.
// Optional watchdog enabled by defining FPU_TIMEOUT_EN.
module fpu_issue_ctrl #(
  parameter int OPC_W       = 4,
  parameter int RD_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  fpu_issue_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GO    = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [OPC_W-1:0] op_q, op_d;
  logic             mode_q, mode_d;
  logic [RD_W-1:0]  rd_q, rd_d;
  logic             int_q, int_d;
  logic [31:0]      data_q, data_d;

  logic             accept_s;
  logic             tmo_hit_s;

  assign accept_s = bus.req_valid && (state_q == S_IDLE);

`ifdef FPU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // Watchdog expiry: the last permitted cycle of WAIT/DRAIN passes without fpu_valid.
  always_comb begin
    tmo_hit_s = 1'b0;
    if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.fpu_valid) begin
      tmo_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Counter restarts whenever WAIT or DRAIN is freshly entered.
  always_comb begin
    cnt_d     = cnt_q;
    tmo_err_d = tmo_err_q | tmo_hit_s;
    if (((state_d == S_WAIT) || (state_d == S_DRAIN)) && (state_d != state_q)) begin
      cnt_d = '0;
    end else if (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !bus.fpu_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog registers; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  // No watchdog in this build; TIMEOUT_CYC only shapes the constant tie-off.
  localparam logic TMO_TIE = (TIMEOUT_CYC > 0) ? 1'b0 : 1'b0;

  assign tmo_hit_s       = 1'b0;
  assign bus.timeout_err = TMO_TIE;
`endif

  // Next-state decode; flush beats a coincident fpu_valid and drops the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_GO;
        else          state_d = S_IDLE;
      end
      S_GO: begin
        if (bus.flush) state_d = S_DRAIN;
        else           state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tmo_hit_s)          state_d = S_IDLE;
        else if (bus.flush)     state_d = bus.fpu_valid ? S_IDLE : S_DRAIN;
        else if (bus.fpu_valid) state_d = S_WB;
        else                    state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (tmo_hit_s || bus.fpu_valid) state_d = S_IDLE;
        else                            state_d = S_DRAIN;
      end
      S_WB: begin
        if (bus.flush || bus.wb_ready) state_d = S_IDLE;
        else                           state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand/tag capture on accept; result capture only on a clean WAIT completion.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    mode_d = mode_q;
    rd_d   = rd_q;
    int_d  = int_q;
    data_d = data_q;
    if (accept_s) begin
      a_d    = bus.req_rs1;
      b_d    = bus.req_rs2;
      op_d   = bus.req_op;
      mode_d = bus.req_mode;
      rd_d   = bus.req_rd;
      int_d  = bus.req_wb_int;
    end else begin
      a_d    = a_q;
      b_d    = b_q;
    end
    if ((state_q == S_WAIT) && (state_d == S_WB)) begin
      data_d = bus.fpu_c;
    end else begin
      data_d = data_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 32'h0000_0000;
      b_q     <= 32'h0000_0000;
      op_q    <= '0;
      mode_q  <= 1'b0;
      rd_q    <= '0;
      int_q   <= 1'b0;
      data_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      rd_q    <= rd_d;
      int_q   <= int_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.fpu_go      = (state_q == S_GO);
  assign bus.wb_valid    = (state_q == S_WB);
  assign bus.fpu_a       = a_q;
  assign bus.fpu_b       = b_q;
  assign bus.fpu_control = op_q;
  assign bus.fpu_mode    = mode_q;
  assign bus.wb_data     = data_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_int      = int_q;

endmodule
